multi_edge_pulser: RTL and testbench

MULTI_EDGE_PULSER -- requirements
Module: multi_edge_pulser

---
 rtl/edge_pulser_pkg.sv | 26 ++
 rtl/edge_pulse_channel.sv | 93 +++++++++
 rtl/multi_edge_pulser.sv | 38 +++
 tb/tb_multi_edge_pulser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_pulser_pkg.sv
// Shared types for the multi-channel edge pulser: edge-select modes, channel states,
// and the edge qualification helper.
package edge_pulser_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // True when the cur/prv transition is a direction enabled by m.
  function automatic logic edge_hit(mode_e m, logic cur, logic prv);
    logic rise_en;
    logic fall_en;
    rise_en  = (m == RISE) || (m == BOTH);
    fall_en  = (m == FALL) || (m == BOTH);
    edge_hit = (rise_en && cur && !prv) || (fall_en && !cur && prv);
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One pulser channel: optional input synchroniser, edge detect and a
// non-retriggerable fixed-width pulse FSM with a sticky overrun flag.
module edge_pulse_channel
  import edge_pulser_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clear_overrun,
  output logic       pulse,
  output logic       overrun,
  output logic       statemon
);

  localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

  logic             s;
  logic             prev;
  logic             edge_det;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = level;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift level in at bit 0; the oldest sample leaves at the top.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= SYNC_STAGES'({sync_q, level});
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_det = edge_hit(mode_e'(mode), s, prev);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev     <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      pulse    <= 1'b0;
      overrun  <= 1'b0;
      statemon <= 1'b0;
    end else begin
      prev <= s;

      // An edge seen while ACTIVE is dropped; flagging it beats a same-cycle clear.
      if (edge_det && (state == ACTIVE)) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (edge_det) begin
            state    <= ACTIVE;
            cnt      <= CNT_W'(PULSE_LEN - 1);
            pulse    <= 1'b1;
            statemon <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            state    <= IDLE;
            pulse    <= 1'b0;
            statemon <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          pulse    <= 1'b0;
          statemon <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_edge_pulser.sv
// Array of independent edge-to-pulse channels sharing one clock, reset and
// overrun-clear strobe.
module multi_edge_pulser
  import edge_pulser_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  clear_overrun,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   overrun,
  output logic [CHANNELS-1:0]   statemon
);

  generate
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      edge_pulse_channel #(
        .PULSE_LEN  (PULSE_LEN),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
        .clock        (clock),
        .reset_n      (reset_n),
        .level        (level[i]),
        .mode         (mode[2*i+1 -: 2]),
        .clear_overrun(clear_overrun),
        .pulse        (pulse[i]),
        .overrun      (overrun[i]),
        .statemon     (statemon[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Directed bench: a 4-channel, 3-cycle, 2-stage instance plus a 1-channel,
// 1-cycle, unsynchronised instance.
module tb_multi_edge_pulser;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] level;
  logic [7:0] mode;
  logic       clear_overrun;
  logic [3:0] pulse;
  logic [3:0] overrun;
  logic [3:0] statemon;

  logic [0:0] level_b;
  logic [1:0] mode_b;
  logic       clear_b;
  logic [0:0] pulse_b;
  logic [0:0] overrun_b;
  logic [0:0] statemon_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] rec;
  logic [31:0] rec2;

  always #5 clock = ~clock;

  multi_edge_pulser #(.CHANNELS(4), .PULSE_LEN(3), .SYNC_STAGES(2)) dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .level        (level),
    .mode         (mode),
    .clear_overrun(clear_overrun),
    .pulse        (pulse),
    .overrun      (overrun),
    .statemon     (statemon)
  );

  multi_edge_pulser #(.CHANNELS(1), .PULSE_LEN(1), .SYNC_STAGES(0)) dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .level        (level_b),
    .mode         (mode_b),
    .clear_overrun(clear_b),
    .pulse        (pulse_b),
    .overrun      (overrun_b),
    .statemon     (statemon_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    level         = '0;
    mode          = '0;
    clear_overrun = 1'b0;
    level_b       = '0;
    mode_b        = 2'b11;
    clear_b       = 1'b0;

    repeat (3) step();
    check("reset_pulse",    32'(pulse),    32'h0);
    check("reset_overrun",  32'(overrun),  32'h0);
    check("reset_statemon", 32'(statemon), 32'h0);
    check("reset_pulse_b",  32'(pulse_b),  32'h0);
    reset_n = 1'b1;
    repeat (2) step();

    // Channel 0 rising only: pulse on steps 2..4, nothing on the fall.
    mode     = 8'h01;
    level[0] = 1'b1;
    rec = '0; rec2 = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rec[i]  = pulse[0];
      rec2[i] = statemon[0];
    end
    check("ch0_rise_pulse",    rec,  32'h1C);
    check("ch0_rise_statemon", rec2, 32'h1C);
    level[0] = 1'b0;
    rec = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rec[i] = pulse[0];
    end
    check("ch0_fall_none", rec, 32'h0);

    // Channel 1 both edges, 10 cycles apart: two clean pulses.
    mode     = 8'h0C;
    level[1] = 1'b1;
    rec = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) level[1] = 1'b0;
      step();
      rec[i] = pulse[1];
    end
    check("ch1_two_pulses", rec, 32'h701C);
    check("ch1_no_overrun", 32'(overrun[1]), 32'h0);

    // Channel 2 edges two cycles apart: second edge lost, overrun sticks.
    mode = 8'h30;
    rec = '0; rec2 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2) level[2] = ~level[2];
      step();
      rec[i]  = pulse[2];
      rec2[i] = overrun[2];
    end
    check("ch2_single_pulse", rec,  32'h1C);
    check("ch2_overrun_seq",  rec2, 32'hF0);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("ch2_cleared", 32'(overrun), 32'h0);

    // Lost edge coinciding with the clear strobe: set wins.
    level[2] = 1'b1;
    step();
    level[2] = 1'b0;
    step();
    step();
    check("ch2_active_before", 32'(pulse[2]), 32'h1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("ch2_set_beats_clear", 32'(overrun[2]), 32'h1);
    repeat (4) step();

    // Channel 3 held high through reset release gives one pulse.
    reset_n = 1'b0;
    level   = 4'b1000;
    mode    = 8'h40;
    repeat (2) step();
    check("reset2_pulse",    32'(pulse),    32'h0);
    check("reset2_overrun",  32'(overrun),  32'h0);
    check("reset2_statemon", 32'(statemon), 32'h0);
    reset_n = 1'b1;
    rec = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rec[i] = pulse[3];
    end
    check("ch3_release_pulse", rec, 32'h1C);

    // Reset in the second pulse cycle kills the pulse at the next edge.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("ch3_pulse_cycle1", 32'(pulse[3]), 32'h1);
    step();
    check("ch3_pulse_cycle2", 32'(pulse[3]), 32'h1);
    reset_n  = 1'b0;
    level[3] = 1'b0;
    step();
    check("ch3_reset_kill_pulse",    32'(pulse[3]),    32'h0);
    check("ch3_reset_kill_statemon", 32'(statemon[3]), 32'h0);
    reset_n = 1'b1;
    repeat (4) step();
    check("ch3_quiet_after", 32'(pulse), 32'h0);

    // All channels at once; mode dropped mid-pulse does not truncate.
    mode  = 8'hFF;
    level = 4'hF;
    step();
    step();
    check("all_before", 32'(pulse), 32'h0);
    step();
    check("all_start", 32'(pulse), 32'hF);
    mode = 8'h00;
    step();
    step();
    check("all_mode_off_hold", 32'(pulse), 32'hF);
    step();
    check("all_end", 32'(pulse), 32'h0);
    level = 4'h0;
    rec = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      rec[i] = |pulse;
    end
    check("mode_off_ignores", rec, 32'h0);

    // Unsynchronised single-cycle instance, toggling every cycle.
    rec = '0; rec2 = '0;
    for (int i = 0; i < 8; i++) begin
      level_b = ~level_b;
      step();
      rec[i]  = pulse_b[0];
      rec2[i] = overrun_b[0];
    end
    check("b_alt_pulses", rec,  32'h55);
    check("b_overrun",    rec2, 32'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
